// File: rtl/segment_bus_cycle_unit_pkg.sv
// Shared types and constants for the segment bus cycle unit and its address generator.
package segment_bus_cycle_unit_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 20;
    localparam int unsigned DATA_W_DEFAULT = 16;

    localparam logic [1:0] SEG_ES = 2'b00;
    localparam logic [1:0] SEG_CS = 2'b01;
    localparam logic [1:0] SEG_SS = 2'b10;
    localparam logic [1:0] SEG_DS = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StT1,
        StT2,
        StT3,
        StTw,
        StT4
    } bus_state_e;

    function automatic logic [15:0] seg_select(input logic [1:0]  sel,
                                               input logic [15:0] es,
                                               input logic [15:0] cs,
                                               input logic [15:0] ss,
                                               input logic [15:0] ds);
        logic [15:0] val;
        unique case (sel)
            SEG_ES:  val = es;
            SEG_CS:  val = cs;
            SEG_SS:  val = ss;
            default: val = ds;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/segment_bus_cycle_unit_phys_addr_gen.sv
// Physical address former: (segment << 4) + offset, carry out of the top bit discarded.
module phys_addr_gen
    import segment_bus_cycle_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [15:0]       seg_i,
    input  logic [15:0]       offset_i,
    output logic [ADDR_W-1:0] addr_o
);

    assign addr_o = ADDR_W'({seg_i, 4'b0000}) + ADDR_W'(offset_i);

endmodule

// File: rtl/segment_bus_cycle_unit.sv
// 8086-style T1..T4 bus cycle engine driven by segment:offset requests.
// Optional abort on excessive wait states when BUS_TIMEOUT_EN is defined.
module segment_bus_cycle_unit
  import segment_bus_cycle_unit_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [1:0]        REQ_SEG,
  input  logic [15:0]       REQ_OFFSET,
  input  logic              REQ_WR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  input  logic [15:0]       Q_CS,
  input  logic [15:0]       Q_DS,
  input  logic [15:0]       Q_ES,
  input  logic [15:0]       Q_SS,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic              BUS_ALE,
  output logic              BUS_RD_N,
  output logic              BUS_WR_N,
  output logic [DATA_W-1:0] BUS_DOUT,
  output logic              BUS_DOUT_EN,
  input  logic [DATA_W-1:0] BUS_DIN,
  input  logic              BUS_READY,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR
);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [15:0]       sel_seg;
  logic [ADDR_W-1:0] phys_addr;
  logic              accept;
  logic              complete;
  logic              strobe_on;
  logic              timeout;

  // Segment is taken from the bank outputs as seen during the accept cycle.
  assign sel_seg = seg_select(REQ_SEG, Q_ES, Q_CS, Q_SS, Q_DS);

  phys_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_phys_addr_gen (
    .seg_i    (sel_seg),
    .offset_i (REQ_OFFSET),
    .addr_o   (phys_addr)
  );

  assign accept   = (state_q == StIdle) && REQ_VALID;
  assign complete = ((state_q == StT3) || (state_q == StTw)) && (state_d == StT4);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned      CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  assign timeout = (state_q == StTw) && (wait_cnt_q >= TIMEOUT_VAL);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == StIdle) begin
      wait_cnt_d = '0;
    end else if (((state_q == StT3) || (state_q == StTw)) && !BUS_READY && !timeout) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (complete) begin
      err_d = timeout;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign RSP_ERR = (state_q == StT4) && err_q;
`else
  assign timeout = 1'b0;
  assign RSP_ERR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (REQ_VALID) state_d = StT1;
      StT1:       state_d = StT2;
      StT2:       state_d = StT3;
      StT3, StTw: begin
        if (BUS_READY || timeout) begin
          state_d = StT4;
        end else begin
          state_d = StTw;
        end
      end
      StT4:       state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = phys_addr;
      wr_d    = REQ_WR;
      wdata_d = REQ_WDATA;
    end
    if (complete) begin
      if (timeout) begin
        rdata_d = '1;
      end else if (!wr_q) begin
        rdata_d = BUS_DIN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes span T2 through the last wait state; T4 releases them.
  assign strobe_on = (state_q == StT2) || (state_q == StT3) || (state_q == StTw);

  assign REQ_READY   = (state_q == StIdle);
  assign BUS_ADDR    = addr_q;
  assign BUS_ALE     = (state_q == StT1);
  assign BUS_RD_N    = !(strobe_on && !wr_q);
  assign BUS_WR_N    = !(strobe_on && wr_q);
  assign BUS_DOUT_EN = strobe_on && wr_q;
  assign BUS_DOUT    = BUS_DOUT_EN ? wdata_q : '0;
  assign RSP_VALID   = (state_q == StT4);
  assign RSP_RDATA   = rdata_q;

endmodule

// File: tb/tb_segment_bus_cycle_unit.sv
// Self-checking bench for segment_bus_cycle_unit: vector table, random traffic, reset and race cases.
module tb_segment_bus_cycle_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_SEG = 2'b00;
  logic [15:0] REQ_OFFSET = 16'h0;
  logic        REQ_WR = 1'b0;
  logic [15:0] REQ_WDATA = 16'h0;
  logic [15:0] Q_CS = 16'h0, Q_DS = 16'h0, Q_ES = 16'h0, Q_SS = 16'h0;
  logic [19:0] BUS_ADDR;
  logic        BUS_ALE, BUS_RD_N, BUS_WR_N, BUS_DOUT_EN;
  logic [15:0] BUS_DOUT;
  logic [15:0] BUS_DIN = 16'h0;
  logic        BUS_READY = 1'b0;
  logic        RSP_VALID, RSP_ERR;
  logic [15:0] RSP_RDATA;

  int          total = 0;
  int          bad = 0;
  logic [15:0] last_rdata = 16'h0;

  always #5 CLK = ~CLK;

  segment_bus_cycle_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_SEG     (REQ_SEG),
    .REQ_OFFSET  (REQ_OFFSET),
    .REQ_WR      (REQ_WR),
    .REQ_WDATA   (REQ_WDATA),
    .Q_CS        (Q_CS),
    .Q_DS        (Q_DS),
    .Q_ES        (Q_ES),
    .Q_SS        (Q_SS),
    .BUS_ADDR    (BUS_ADDR),
    .BUS_ALE     (BUS_ALE),
    .BUS_RD_N    (BUS_RD_N),
    .BUS_WR_N    (BUS_WR_N),
    .BUS_DOUT    (BUS_DOUT),
    .BUS_DOUT_EN (BUS_DOUT_EN),
    .BUS_DIN     (BUS_DIN),
    .BUS_READY   (BUS_READY),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: 8086 physical address, 1 MiB wrap.
  function automatic logic [19:0] model_addr(input logic [15:0] seg, input logic [15:0] off);
    int a;
    a = (int'(seg) * 16 + int'(off)) % 1048576;
    return a[19:0];
  endfunction

  function automatic logic [15:0] model_seg(input logic [1:0] sel);
    case (sel)
      2'b00:   return Q_ES;
      2'b01:   return Q_CS;
      2'b10:   return Q_SS;
      default: return Q_DS;
    endcase
  endfunction

  task automatic set_seg(input logic [1:0] sel, input logic [15:0] val);
    Q_ES = 16'h0E11; Q_CS = 16'h0C22; Q_SS = 16'h0533; Q_DS = 16'h0D44;
    case (sel)
      2'b00:   Q_ES = val;
      2'b01:   Q_CS = val;
      2'b10:   Q_SS = val;
      default: Q_DS = val;
    endcase
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, BUS_ADDR, 0);
    chk({tag, "_ale"}, BUS_ALE, 0);
    chk({tag, "_rd_n"}, BUS_RD_N, 1);
    chk({tag, "_wr_n"}, BUS_WR_N, 1);
    chk({tag, "_dout"}, BUS_DOUT, 0);
    chk({tag, "_dout_en"}, BUS_DOUT_EN, 0);
    chk({tag, "_rsp_valid"}, RSP_VALID, 0);
    chk({tag, "_rdata"}, RSP_RDATA, 0);
    chk({tag, "_err"}, RSP_ERR, 0);
  endtask

  // Runs one transaction from a negedge in IDLE. BUS_READY is low for `waits` cycles from T3.
  task automatic run_txn(input string name, input logic [1:0] sel, input logic [15:0] off,
                         input logic wr, input logic [15:0] wdata, input int waits,
                         input logic [15:0] din, input logic race, input logic [15:0] race_val,
                         input logic [19:0] exp_addr, input int exp_lat, input logic exp_err);
    int          rsp_c = -1;
    int          ale_n = 0, ale_c = -1, strb_n = 0, strb_first = -1;
    bit          both_low = 0, other_low = 0, en_bad = 0, dout_bad = 0, addr_bad = 0;
    logic        strobe;
    logic [15:0] exp_rdata;
    logic [15:0] got_rdata = 16'h0;
    logic        got_err = 1'b0;

    exp_rdata = exp_err ? 16'hFFFF : (wr ? last_rdata : din);
    chk({name, "_ready_idle"}, REQ_READY, 1);
    REQ_VALID = 1'b1; REQ_SEG = sel; REQ_OFFSET = off; REQ_WR = wr; REQ_WDATA = wdata;
    BUS_DIN = din; BUS_READY = 1'b0;
    @(posedge CLK);
    #1;
    if (race) Q_ES = race_val;
    REQ_VALID = 1'b0; REQ_OFFSET = ~off; REQ_WDATA = ~wdata; REQ_WR = ~wr;
    for (int c = 1; c <= exp_lat + 4 && rsp_c < 0; c++) begin
      @(negedge CLK);
      if (BUS_ALE) begin ale_n++; ale_c = c; end
      if (!BUS_RD_N && !BUS_WR_N) both_low = 1;
      strobe = wr ? !BUS_WR_N : !BUS_RD_N;
      if (wr ? !BUS_RD_N : !BUS_WR_N) other_low = 1;
      if (strobe) begin
        strb_n++;
        if (strb_first < 0) strb_first = c;
      end
      if (BUS_DOUT_EN !== (wr && strobe)) en_bad = 1;
      if (BUS_DOUT_EN && BUS_DOUT !== wdata) dout_bad = 1;
      if (BUS_ADDR !== exp_addr) addr_bad = 1;
      if (RSP_VALID) begin
        rsp_c = c; got_rdata = RSP_RDATA; got_err = RSP_ERR;
      end
      BUS_READY = (c >= 3 + waits);
    end
    chk({name, "_latency"}, rsp_c, exp_lat);
    chk({name, "_ale_count"}, ale_n, 1);
    chk({name, "_ale_cycle"}, ale_c, 1);
    chk({name, "_strobe_cycles"}, strb_n, exp_lat - 2);
    chk({name, "_strobe_first"}, strb_first, 2);
    chk({name, "_wrong_strobe"}, {31'b0, other_low | both_low}, 0);
    chk({name, "_dout_en"}, en_bad, 0);
    chk({name, "_dout"}, dout_bad, 0);
    chk({name, "_addr"}, addr_bad, 0);
    chk({name, "_rdata"}, got_rdata, exp_rdata);
    chk({name, "_err"}, got_err, exp_err);
    @(negedge CLK);
    chk({name, "_ready_after"}, REQ_READY, 1);
    chk({name, "_rsp_single"}, RSP_VALID, 0);
    chk({name, "_addr_held"}, BUS_ADDR, exp_addr);
    chk({name, "_rdata_held"}, RSP_RDATA, exp_rdata);
    BUS_READY = 1'b0;
    last_rdata = exp_rdata;
  endtask

  // Starts a transaction and asserts reset in cycle at_c after accept.
  task automatic reset_mid(input string name, input logic wr, input int at_c);
    bit seen = 0;
    REQ_VALID = 1'b1; REQ_SEG = 2'b01; REQ_OFFSET = 16'h0042; REQ_WR = wr;
    REQ_WDATA = 16'h7777; BUS_READY = 1'b0;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
    repeat (at_c) @(negedge CLK);
    chk({name, "_strobe_before"}, wr ? BUS_WR_N : BUS_RD_N, 0);
    #1 RST = 1'b0;
    #1 check_reset(name);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk({name, "_ready_release"}, REQ_READY, 1);
    BUS_READY = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (RSP_VALID) seen = 1;
    end
    chk({name, "_no_rsp"}, seen, 0);
    BUS_READY = 1'b0;
    last_rdata = 16'h0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [15:0] segval;
    logic [15:0] off;
    logic        wr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] din;
    logic [19:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"rd_cs",      2'b01, 16'h1234, 16'h0010, 1'b0, 16'h0000, 0, 16'hBEEF, 20'h12350};
    vecs[1] = '{"wr_ds",      2'b11, 16'h2000, 16'h0004, 1'b1, 16'hA5A5, 2, 16'h0000, 20'h20004};
    vecs[2] = '{"wrap_ss",    2'b10, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1, 16'h1357, 20'h0FFEF};
    vecs[3] = '{"zero_es",    2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3, 16'h8001, 20'h00000};
    vecs[4] = '{"wr_es",      2'b00, 16'hABCD, 16'h1234, 1'b1, 16'h5A5A, 0, 16'h0000, 20'hACF04};
    vecs[5] = '{"rd_cs_hi",   2'b01, 16'hF000, 16'h8000, 1'b0, 16'h0000, 0, 16'h7E7E, 20'hF8000};
    vecs[6] = '{"wr_ds_wrap", 2'b11, 16'hFFFF, 16'h0010, 1'b1, 16'h1234, 1, 16'h0000, 20'h00000};

    #1 check_reset("por");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("por_ready", REQ_READY, 1);

    for (int i = 0; i < 7; i++) begin
      set_seg(vecs[i].sel, vecs[i].segval);
      run_txn(vecs[i].name, vecs[i].sel, vecs[i].off, vecs[i].wr, vecs[i].wdata,
              vecs[i].waits, vecs[i].din, 1'b0, 16'h0, vecs[i].exp_addr,
              4 + vecs[i].waits, 1'b0);
    end

    // Bank write in the accept cycle must not affect the address.
    set_seg(2'b00, 16'h1000);
    run_txn("race_es", 2'b00, 16'h0020, 1'b0, 16'h0, 0, 16'h4321, 1'b1, 16'h2000,
            20'h10020, 4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sel;
      logic [15:0] off;
      int          w;
      Q_ES = 16'($urandom); Q_CS = 16'($urandom);
      Q_SS = 16'($urandom); Q_DS = 16'($urandom);
      sel = 2'($urandom);
      off = 16'($urandom);
      w = int'($urandom_range(3, 0));
      run_txn("rand", sel, off, 1'($urandom), 16'($urandom), w, 16'($urandom),
              1'b0, 16'h0, model_addr(model_seg(sel), off), 4 + w, 1'b0);
    end

    reset_mid("rst_t2_rd", 1'b0, 2);
    set_seg(2'b01, 16'h0300);
    run_txn("post_rst", 2'b01, 16'h0005, 1'b1, 16'hC0DE, 0, 16'h0, 1'b0, 16'h0,
            20'h03005, 4, 1'b0);
    reset_mid("rst_t3_wr", 1'b1, 3);

`ifdef BUS_TIMEOUT_EN
    set_seg(2'b11, 16'h4000);
    run_txn("timeout", 2'b11, 16'h0100, 1'b0, 16'h0, 1000, 16'h1111, 1'b0, 16'h0,
            20'h40100, 8, 1'b1);
    set_seg(2'b10, 16'h0010);
    run_txn("after_to", 2'b10, 16'h0001, 1'b0, 16'h0, 3, 16'h2222, 1'b0, 16'h0,
            20'h00101, 7, 1'b0);
`else
    set_seg(2'b11, 16'h4000);
    run_txn("long_wait", 2'b11, 16'h0100, 1'b0, 16'h0, 20, 16'h1111, 1'b0, 16'h0,
            20'h40100, 24, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
